// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch port.
//   NOP_INSTR      : instruction returned when no valid word is presented
//                    (addi x0,x0,0).
//   FAULT_MISALIGN : rsp_fault bit flagging a byte address not on a word boundary.
//   FAULT_OOB      : rsp_fault bit flagging a byte address beyond the stored words.
//   idx_w()        : width of a word index for a given depth.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam int          FAULT_MISALIGN = 0;
    localparam int          FAULT_OOB      = 1;

    // A depth of 1 would give a zero-width index, so clamp to one bit.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_word_ram.sv
// Word-organised storage for the fetch port: one synchronous write port and
// one synchronous, registered read port.
//   clk     : clock, all activity on the rising edge
//   wr_en   : write strobe
//   wr_addr : word index written
//   wr_data : word written
//   rd_en   : read strobe; rd_data only changes when this is high
//   rd_addr : word index read
//   rd_data : registered read data
// A same-edge read and write of one word returns the old contents.
module imem_word_ram
    import imem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 16,
    localparam int IDX_W      = idx_w(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [XLEN-1:0]  rd_data
);

    logic [XLEN-1:0] mem_reg [DEPTH_WORDS];
    logic [XLEN-1:0] rd_data_reg;

    // Both updates are non-blocking, so a colliding read samples the word
    // as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with a valid/ready fetch port for the RV32I core.
// Requests are checked for alignment and range, the word array is read on
// acceptance, and the result sits in a single response stage that supports
// backpressure and a branch flush. A loader port writes program words.
//   clk, rst_n           : clock and asynchronous active-low reset
//   req_valid/req_ready  : fetch request handshake
//   req_addr             : byte address of the instruction
//   rsp_valid/rsp_ready  : response handshake
//   rsp_instr            : fetched instruction (NOP_INSTR on fault/empty)
//   rsp_fault            : bit0 misaligned, bit1 out of range
//   flush                : drop the held response (taken branch/jump)
//   ld_en/ld_addr/ld_data: loader word write
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              ADDR_W      = 32,
    parameter int              DEPTH_WORDS = 16,
    parameter logic [XLEN-1:0] NOP_INSTR   = imem_pkg::NOP_INSTR
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_W-1:0]                 req_addr,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [XLEN-1:0]                   rsp_instr,
    output logic [1:0]                        rsp_fault,
    input  logic                              flush,
    input  logic                              ld_en,
    input  logic [idx_w(DEPTH_WORDS)-1:0]     ld_addr,
    input  logic [XLEN-1:0]                   ld_data
);

    localparam int              IDX_W      = idx_w(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH_WORDS * 4);

    logic             rsp_valid_reg;
    logic [1:0]       fault_reg;
    logic [1:0]       fault_next;
    logic             accept;
    logic             rd_en;
    logic [XLEN-1:0]  rd_data;

    always_comb begin
        req_ready = !rsp_valid_reg || rsp_ready || flush;
        accept    = req_valid && req_ready;

        fault_next                 = 2'b00;
        fault_next[FAULT_MISALIGN] = (req_addr[1:0] != 2'b00);
        // Full-width compare: high addresses fault rather than alias low.
        fault_next[FAULT_OOB]      = (req_addr >= ADDR_LIMIT);

        // A faulting request leaves the array untouched.
        rd_en = accept && (fault_next == 2'b00);
    end

    imem_word_ram #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (rd_en),
        .rd_addr (req_addr[IDX_W+1:2]),
        .rd_data (rd_data)
    );

    // The RAM's read register is the data half of the response stage; this
    // block holds its valid and fault qualifiers. A new accept takes priority
    // over flush so the post-branch fetch survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            fault_reg     <= 2'b00;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            fault_reg     <= fault_next;
        end else if (flush || rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            fault_reg     <= 2'b00;
        end
    end

    // rd_data only moves on a non-faulting accept, so a stalled response
    // stays stable and loader writes cannot disturb it.
    assign rsp_valid = rsp_valid_reg;
    assign rsp_fault = fault_reg;
    assign rsp_instr = (rsp_valid_reg && (fault_reg == 2'b00)) ? rd_data : NOP_INSTR;

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
- Parametrised instruction memory for the RV32I core. Successor to the combinational byte-array instruction ROM.
- Word-organised storage with a synchronous read and a valid/ready fetch handshake.
- Registered response stage with backpressure and a flush for taken branches/jumps.
- Adds a loader write port, so program images are written at run time rather than fixed in the source.
- Sits between the PC/fetch logic and the decode stage.

Parameters:
- XLEN, 32, instruction and load-data width in bits.
- ADDR_W, 32, byte-address width of fetch requests.
- DEPTH_WORDS, 16, number of XLEN-bit words stored (16 words = 64 bytes); power of two, at least 2.
- NOP_INSTR, 32'h0000_0013, value returned on reset, fault or flush (addi x0,x0,0).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: fetch request present.
- req_ready, output, 1: block accepts the request this cycle.
- req_addr, input, ADDR_W: byte address of the instruction.
- rsp_valid, output, 1: response held in the output register.
- rsp_ready, input, 1: consumer takes the response this cycle.
- rsp_instr, output, XLEN: fetched instruction; little-endian, so bits [7:0] are the byte at req_addr.
- rsp_fault, output, 2: bit0 = misaligned, bit1 = out of range.
- flush, input, 1: discard the held response.
- ld_en, input, 1: loader write strobe.
- ld_addr, input, clog2(DEPTH_WORDS): word index for the loader write.
- ld_data, input, XLEN: word to write.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - rsp_valid=0, rsp_instr=NOP_INSTR, rsp_fault=0.
  - Memory array is not cleared; contents are undefined until loaded.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready || flush (pipelined single stage).
  - A request is accepted when req_valid && req_ready.
  - Latency is 1 cycle: the response appears in the cycle after acceptance, with rsp_valid=1.
- Hold:
  - While rsp_valid && !rsp_ready && !flush, rsp_instr and rsp_fault hold stable and req_ready=0.
- Address checks, evaluated on acceptance:
  - req_addr[1:0] != 0: rsp_fault[0]=1.
  - req_addr >= DEPTH_WORDS*4: rsp_fault[1]=1.
  - Both faults may be set together.
  - Any fault: rsp_instr = NOP_INSTR and the array is not read.
  - Otherwise: rsp_instr = mem[req_addr >> 2].
- Pipeline update:
  - Accept with no consumption is a normal load of the output register.
  - rsp_ready with no new accept: rsp_valid falls to 0.
  - Accept and consume in the same cycle: back-to-back throughput of 1 fetch per cycle.
- Flush:
  - Clears the held response in the same edge.
  - A request accepted in the flush cycle is the new post-branch fetch and is kept; it becomes rsp_valid next cycle.
  - Flush with no accept: rsp_valid=0, rsp_instr=NOP_INSTR.
- Loader:
  - When ld_en=1, mem[ld_addr] <= ld_data at the edge.
  - ld_addr is always in range by width.
  - A write never modifies an already registered response.
- Read/write collision: same-cycle fetch and load of the same word returns the OLD word (read-before-write); the new word is visible to the next fetch.
- Wrap-around: none. Addresses at or beyond the top fault; they never alias into low memory.
- Reset mid-response: the response is dropped; no accept occurs while rst_n=0.

Decomposition:
- Shared package imem_pkg:
  - NOP_INSTR constant.
  - Fault bit indices: FAULT_MISALIGN=0, FAULT_OOB=1.
  - Function for the word-index width, clog2(DEPTH_WORDS).
- One sub-module, imem_word_ram:
  - DEPTH_WORDS x XLEN array.
  - One synchronous write port and one synchronous read port.
  - Read-before-write on collision.
- The top level holds the handshake, fault logic and output register.

Test Plan:
- Reset then load words 0..7 with known values (word1 = 32'h0093_8333); req addr 4 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_instr=32'h0093_8333, rsp_fault=0.
- Stream addr 0,4,8,12 on consecutive cycles with rsp_ready=1 -> one response per cycle, in order, req_ready held 1.
- Response held with rsp_ready=0 for 3 cycles -> req_ready=0 and rsp_instr stable; then rsp_ready=1 -> next request accepted in that cycle.
- req addr 6 -> rsp_fault=2'b01, rsp_instr=32'h0000_0013; req addr 64 (DEPTH_WORDS=16) -> rsp_fault=2'b10, NOP; req addr 66 -> rsp_fault=2'b11, NOP.
- Fetch addr 8 while ld_en writes word 2 = 32'hDEAD_BEEF in the same cycle -> old word returned; the next fetch of addr 8 returns 32'hDEAD_BEEF.
- Response pending with rsp_ready=0, then flush with a new req at addr 28 -> old response discarded; next cycle rsp_instr = mem[7]. Assert rst_n=0 mid-stream -> rsp_valid=0 immediately, without waiting for a clock edge.
